sync_ram_v2: RTL



---
 rtl/sync_ram_v2.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sync_ram_v2.sv
// Single-port synchronous RAM with request/ready handshake, byte enables,
// 1/2-cycle read latency, hardware clear engine; parity via SYNC_RAM_PARITY_EN.
module sync_ram_v2 #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int RD_LAT = 1,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] be,
    input  logic            clr,
`ifdef SYNC_RAM_PARITY_EN
    input  logic            inj_err,
    output logic            par_err,
`endif
    output logic            ready,
    output logic [DW-1:0]   rdata,
    output logic            rvalid
);

    localparam int NB = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_word;
    logic          acc;
    logic          wr;
    logic          rd;
    logic          pipe_v;
    logic [DW-1:0] pipe_d;

    assign ready   = (state == IDLE);
    assign acc     = cs & req & ready;
    assign wr      = acc & we;
    assign rd      = acc & ~we;
    assign rd_word = mem[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (&cnt) state_nx = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    // Storage is not reset; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= CLR_VAL;
        end else if (wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];
    logic [NB-1:0] rd_par;
    logic          err_now;
    logic          pipe_e;

    assign rd_par = pmem[addr];

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            for (int i = 0; i < NB; i++) begin
                pmem[cnt][i] <= ^CLR_VAL[8*i +: 8];
            end
        end else if (wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) pmem[addr][i] <= ^wdata[8*i +: 8] ^ inj_err;
            end
        end
    end

    always_comb begin
        err_now = 1'b0;
        for (int i = 0; i < NB; i++) begin
            err_now = err_now | (^{rd_word[8*i +: 8], rd_par[i]});
        end
    end
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          v1;
            logic [DW-1:0] d1;
`ifdef SYNC_RAM_PARITY_EN
            logic          e1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) e1 <= 1'b0;
                else if (rd) e1 <= err_now;
            end
            assign pipe_e = e1;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1 <= 1'b0;
                    d1 <= '0;
                end else begin
                    v1 <= rd;
                    if (rd) d1 <= rd_word;
                end
            end
            assign pipe_v = v1;
            assign pipe_d = d1;
        end else begin : g_lat1
            assign pipe_v = rd;
            assign pipe_d = rd_word;
`ifdef SYNC_RAM_PARITY_EN
            assign pipe_e = err_now;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= pipe_v;
            if (pipe_v) rdata <= pipe_d;
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else par_err <= pipe_v & pipe_e;
    end
`endif

endmodule
